// File: rtl/tag_gate_filter.sv
// tag_gate_filter: registered tag-word stage that drops events by
// channel enable mask and a start/stop driven gate, with event counters.
module tag_gate_filter #(
    parameter int WORD_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axis_tvalid,
    input  logic [63:0]             s_axis_tagtime [WORD_WIDTH],
    input  logic signed [5:0]       s_axis_channel [WORD_WIDTH],
    input  logic [WORD_WIDTH-1:0]   s_axis_tkeep,
    input  logic [63:0]             s_lowest_time_bound,
    output logic                    m_axis_tvalid,
    output logic [63:0]             m_axis_tagtime [WORD_WIDTH],
    output logic signed [5:0]       m_axis_channel [WORD_WIDTH],
    output logic [WORD_WIDTH-1:0]   m_axis_tkeep,
    output logic [63:0]             m_lowest_time_bound,
    input  logic                    config_en_i,
    input  logic [35:0]             enable_mask_i,
    input  logic [35:0]             gated_mask_i,
    input  logic signed [5:0]       gate_start_channel_i,
    input  logic signed [5:0]       gate_stop_channel_i,
    input  logic                    counter_clear_i,
    output logic [31:0]             passed_count_o,
    output logic [31:0]             dropped_count_o,
    output logic                    gate_open_o
);

    logic [35:0]       en_mask;
    logic [35:0]       gt_mask;
    logic signed [5:0] start_ch;
    logic signed [5:0] stop_ch;
    logic              gate_q;
    logic              gate_open_q;
    logic [31:0]       passed_cnt;
    logic [31:0]       dropped_cnt;

    logic [WORD_WIDTH-1:0] keep_d;
    logic                  gate_d;
    logic                  gate_open_d;
    logic [31:0]           pass_inc;
    logic [31:0]           all_inc;
    logic [31:0]           drop_inc;

    // {valid, bit index}: +c -> c-1, -c -> 17+c, anything else invalid
    function automatic logic [6:0] ch_index(input logic signed [5:0] ch);
        int c;
        c = int'(ch);
        if (c >= 1 && c <= 18) begin
            return {1'b1, 6'(c - 1)};
        end else if (c <= -1 && c >= -18) begin
            return {1'b1, 6'(17 - c)};
        end
        return 7'd0;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Walk lanes in time order, deciding each lane on the gate state before it
    always_comb begin
        logic       g;
        logic [6:0] ci;
        g        = (start_ch == 6'sd0) ? 1'b1 : gate_q;
        ci       = '0;
        keep_d   = '0;
        pass_inc = '0;
        all_inc  = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (s_axis_tvalid && s_axis_tkeep[i]) begin
                ci      = ch_index(s_axis_channel[i]);
                all_inc = all_inc + 32'd1;
                if (ci[6] && en_mask[ci[5:0]] && (!gt_mask[ci[5:0]] || g)) begin
                    keep_d[i] = 1'b1;
                    pass_inc  = pass_inc + 32'd1;
                end
                if (start_ch != 6'sd0) begin
                    if (start_ch == stop_ch) begin
                        if (s_axis_channel[i] == start_ch) g = ~g;
                    end else if (s_axis_channel[i] == start_ch) begin
                        g = 1'b1;
                    end else if (s_axis_channel[i] == stop_ch) begin
                        g = 1'b0;
                    end
                end
            end
        end
        drop_inc = all_inc - pass_inc;
        if (config_en_i) begin
            gate_d      = 1'b0;
            gate_open_d = (gate_start_channel_i == 6'sd0);
        end else begin
            gate_d      = (start_ch == 6'sd0) ? 1'b0 : g;
            gate_open_d = g;
        end
    end

    // Data path register: word forwarded unchanged except for tkeep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid       <= 1'b0;
            m_axis_tkeep        <= '0;
            m_lowest_time_bound <= '0;
            for (int i = 0; i < WORD_WIDTH; i++) begin
                m_axis_tagtime[i] <= '0;
                m_axis_channel[i] <= '0;
            end
        end else begin
            m_axis_tvalid       <= s_axis_tvalid;
            m_axis_tkeep        <= keep_d;
            m_lowest_time_bound <= s_lowest_time_bound;
            for (int i = 0; i < WORD_WIDTH; i++) begin
                m_axis_tagtime[i] <= s_axis_tagtime[i];
                m_axis_channel[i] <= s_axis_channel[i];
            end
        end
    end

    // Config latch and gate state; a config write always closes the gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_mask     <= '1;
            gt_mask     <= '0;
            start_ch    <= '0;
            stop_ch     <= '0;
            gate_q      <= 1'b0;
            gate_open_q <= 1'b0;
        end else begin
            if (config_en_i) begin
                en_mask  <= enable_mask_i;
                gt_mask  <= gated_mask_i;
                start_ch <= gate_start_channel_i;
                stop_ch  <= gate_stop_channel_i;
            end
            gate_q      <= gate_d;
            gate_open_q <= gate_open_d;
        end
    end

    // Saturating statistics; clear wins over the same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passed_cnt  <= '0;
            dropped_cnt <= '0;
        end else if (counter_clear_i) begin
            passed_cnt  <= '0;
            dropped_cnt <= '0;
        end else begin
            passed_cnt  <= sat_add(passed_cnt, pass_inc);
            dropped_cnt <= sat_add(dropped_cnt, drop_inc);
        end
    end

    assign passed_count_o  = passed_cnt;
    assign dropped_count_o = dropped_cnt;
    assign gate_open_o     = gate_open_q;

endmodule

// File: tb/tb_tag_gate_filter.sv
// tb_tag_gate_filter: table-driven directed vectors plus hand sequences
// for counter saturation, clear priority and asynchronous reset.
module tb_tag_gate_filter;

    localparam int W = 4;
    localparam logic [35:0] ALL = 36'hF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_axis_tvalid;
    logic [63:0]       s_axis_tagtime [W];
    logic signed [5:0] s_axis_channel [W];
    logic [W-1:0]      s_axis_tkeep;
    logic [63:0]       s_lowest_time_bound;
    logic              m_axis_tvalid;
    logic [63:0]       m_axis_tagtime [W];
    logic signed [5:0] m_axis_channel [W];
    logic [W-1:0]      m_axis_tkeep;
    logic [63:0]       m_lowest_time_bound;
    logic              config_en_i;
    logic [35:0]       enable_mask_i;
    logic [35:0]       gated_mask_i;
    logic signed [5:0] gate_start_channel_i;
    logic signed [5:0] gate_stop_channel_i;
    logic              counter_clear_i;
    logic [31:0]       passed_count_o;
    logic [31:0]       dropped_count_o;
    logic              gate_open_o;

    tag_gate_filter #(.WORD_WIDTH(W)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tagtime       (s_axis_tagtime),
        .s_axis_channel       (s_axis_channel),
        .s_axis_tkeep         (s_axis_tkeep),
        .s_lowest_time_bound  (s_lowest_time_bound),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tagtime       (m_axis_tagtime),
        .m_axis_channel       (m_axis_channel),
        .m_axis_tkeep         (m_axis_tkeep),
        .m_lowest_time_bound  (m_lowest_time_bound),
        .config_en_i          (config_en_i),
        .enable_mask_i        (enable_mask_i),
        .gated_mask_i         (gated_mask_i),
        .gate_start_channel_i (gate_start_channel_i),
        .gate_stop_channel_i  (gate_stop_channel_i),
        .counter_clear_i      (counter_clear_i),
        .passed_count_o       (passed_count_o),
        .dropped_count_o      (dropped_count_o),
        .gate_open_o          (gate_open_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg;
        logic [35:0] en;
        logic [35:0] gt;
        int          st;
        int          sp;
        logic        tv;
        logic [3:0]  keep;
        logic [23:0] chs;
        logic [3:0]  ek;
        logic        eg;
        logic [31:0] ep;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[$];

    int total = 0;
    int bad   = 0;

    logic [63:0]       exp_time [W];
    logic signed [5:0] exp_ch   [W];
    logic              exp_tv;
    logic [63:0]       exp_bound;

    function automatic logic [23:0] pk(int a, int b, int c, int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic vec_t mk(logic cfg, logic [35:0] en, logic [35:0] gt,
                                int st, int sp, logic tv, logic [3:0] keep,
                                logic [23:0] chs, logic [3:0] ek, logic eg,
                                logic [31:0] ep, logic [31:0] ed);
        vec_t v;
        v.cfg = cfg; v.en = en; v.gt = gt; v.st = st; v.sp = sp;
        v.tv = tv; v.keep = keep; v.chs = chs;
        v.ek = ek; v.eg = eg; v.ep = ep; v.ed = ed;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of stimulus at negedge, return 1ns after the edge
    task automatic drive(logic cfg, logic [35:0] en, logic [35:0] gt,
                         int st, int sp, logic clr, logic tv,
                         logic [3:0] keep, logic [23:0] chs, int tag);
        @(negedge clk);
        config_en_i          = cfg;
        enable_mask_i        = en;
        gated_mask_i         = gt;
        gate_start_channel_i = 6'(st);
        gate_stop_channel_i  = 6'(sp);
        counter_clear_i      = clr;
        s_axis_tvalid        = tv;
        s_axis_tkeep         = keep;
        s_lowest_time_bound  = 64'(tag) * 64'd1000 + 64'd7;
        for (int i = 0; i < W; i++) begin
            s_axis_channel[i] = chs[6*i +: 6];
            s_axis_tagtime[i] = 64'(tag) * 64'd100 + 64'(i) + 64'h1_0000_0000;
            exp_ch[i]   = chs[6*i +: 6];
            exp_time[i] = s_axis_tagtime[i];
        end
        exp_tv    = tv;
        exp_bound = s_lowest_time_bound;
        @(posedge clk);
        #1;
        config_en_i     = 1'b0;
        counter_clear_i = 1'b0;
        s_axis_tvalid   = 1'b0;
    endtask

    task automatic chk_out(string nm, logic [3:0] ek, logic eg,
                           logic [31:0] ep, logic [31:0] ed);
        chk({nm, " tvalid"}, 64'(m_axis_tvalid), 64'(exp_tv));
        chk({nm, " tkeep"}, 64'(m_axis_tkeep), 64'(ek));
        chk({nm, " gate"}, 64'(gate_open_o), 64'(eg));
        chk({nm, " passed"}, 64'(passed_count_o), 64'(ep));
        chk({nm, " dropped"}, 64'(dropped_count_o), 64'(ed));
        chk({nm, " bound"}, m_lowest_time_bound, exp_bound);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("%s time%0d", nm, i), m_axis_tagtime[i], exp_time[i]);
            chk($sformatf("%s ch%0d", nm, i), 64'(m_axis_channel[i]), 64'(exp_ch[i]));
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        s_axis_tvalid        = 1'b0;
        s_axis_tkeep         = '0;
        s_lowest_time_bound  = '0;
        config_en_i          = 1'b0;
        enable_mask_i        = '0;
        gated_mask_i         = '0;
        gate_start_channel_i = '0;
        gate_stop_channel_i  = '0;
        counter_clear_i      = 1'b0;
        for (int i = 0; i < W; i++) begin
            s_axis_tagtime[i] = '0;
            s_axis_channel[i] = '0;
        end

        //            cfg  en    gt      st sp tv keep     chs               ek       eg  pass drop
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b1111, pk(1, 2, -3, 18), 4'b1111, 1,  4,  0));
        tbl.push_back(mk(1, 36'h1, 36'h0, 0, 0, 0, 4'b0000, pk(0, 0, 0, 0),  4'b0000, 1,  4,  0));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b1111, pk(1, 2, 1, -1),  4'b0101, 1,  6,  2));
        tbl.push_back(mk(1, ALL, 36'h1,  5, 6, 0, 4'b0000, pk(0, 0, 0, 0),   4'b0000, 0,  6,  2));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b1111, pk(1, 5, 1, 6),   4'b1110, 0,  9,  3));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b0001, pk(5, 1, 1, 1),   4'b0001, 1, 10,  3));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b1111, pk(1, 1, 6, 1),   4'b0111, 0, 13,  4));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 0, 4'b1111, pk(5, 5, 5, 5),   4'b0000, 0, 13,  4));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b0001, pk(5, 0, 0, 0),   4'b0001, 1, 14,  4));
        tbl.push_back(mk(1, ALL, 36'h1,  5, 6, 0, 4'b0000, pk(0, 0, 0, 0),   4'b0000, 0, 14,  4));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b0001, pk(1, 0, 0, 0),   4'b0000, 0, 14,  5));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b0001, pk(5, 0, 0, 0),   4'b0001, 1, 15,  5));
        tbl.push_back(mk(1, ALL, 36'h1,  5, 6, 1, 4'b0001, pk(1, 0, 0, 0),   4'b0001, 0, 16,  5));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b0001, pk(1, 0, 0, 0),   4'b0000, 0, 16,  6));
        tbl.push_back(mk(1, ALL, 36'h0,  0, 0, 0, 4'b0000, pk(0, 0, 0, 0),   4'b0000, 1, 16,  6));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b1111, pk(0, 19, -19, -18), 4'b1000, 1, 17, 9));
        tbl.push_back(mk(1, ALL, 36'h41, 7, 7, 0, 4'b0000, pk(0, 0, 0, 0),   4'b0000, 0, 17,  9));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b1111, pk(1, 7, 1, 7),   4'b1100, 0, 19, 11));
        tbl.push_back(mk(0, ALL, 36'h0,  0, 0, 1, 4'b0101, pk(7, 1, 1, 1),   4'b0100, 1, 20, 12));

        #2;
        chk("rst tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst gate", 64'(gate_open_o), 64'd0);
        chk("rst passed", 64'(passed_count_o), 64'd0);
        chk("rst dropped", 64'(dropped_count_o), 64'd0);
        chk("rst time0", m_axis_tagtime[0], 64'd0);
        chk("rst bound", m_lowest_time_bound, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].cfg, tbl[n].en, tbl[n].gt, tbl[n].st, tbl[n].sp,
                  1'b0, tbl[n].tv, tbl[n].keep, tbl[n].chs, n + 1);
            chk_out($sformatf("v%0d", n), tbl[n].ek, tbl[n].eg,
                    tbl[n].ep, tbl[n].ed);
        end

        // Saturation of the dropped counter from a preloaded value
        @(negedge clk);
        force dut.dropped_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.dropped_cnt;
        drive(0, ALL, 36'h0, 0, 0, 0, 1, 4'b1111, pk(0, 0, 0, 0), 40);
        chk_out("sat1", 4'b0000, 1, 20, 32'hFFFF_FFFF);
        drive(0, ALL, 36'h0, 0, 0, 0, 1, 4'b1111, pk(0, 0, 0, 0), 41);
        chk_out("sat2", 4'b0000, 1, 20, 32'hFFFF_FFFF);

        // Clear and config in the same cycle as a passing word
        drive(1, ALL, 36'h0, 0, 0, 1, 1, 4'b0011, pk(-18, 2, 0, 0), 42);
        chk_out("clr", 4'b0011, 1, 0, 0);
        drive(0, ALL, 36'h0, 0, 0, 0, 1, 4'b0001, pk(3, 0, 0, 0), 43);
        chk_out("post clr", 4'b0001, 1, 1, 0);

        // Async reset mid-cycle restores pass-through config
        drive(1, 36'h0, 36'h0, 5, 6, 0, 0, 4'b0000, pk(0, 0, 0, 0), 44);
        chk_out("dis cfg", 4'b0000, 0, 1, 0);
        drive(0, ALL, 36'h0, 0, 0, 0, 1, 4'b0011, pk(1, 2, 0, 0), 45);
        chk_out("dis word", 4'b0000, 0, 1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("arst tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("arst passed", 64'(passed_count_o), 64'd0);
        chk("arst dropped", 64'(dropped_count_o), 64'd0);
        chk("arst gate", 64'(gate_open_o), 64'd0);
        chk("arst time0", m_axis_tagtime[0], 64'd0);
        rst_n = 1'b1;
        drive(0, ALL, 36'h0, 0, 0, 0, 1, 4'b1111, pk(2, 3, -4, 5), 46);
        chk_out("after arst", 4'b1111, 1, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
